// File: rtl/ov5640_sccb_cfg.sv
// OV5640 SCCB register-table writer, started by the power-up sequencer.
// Define SCCB_ACK_CHK_EN for ACK checking, per-entry retries and cfg_err.
module ov5640_sccb_cfg #(
  parameter int          SCL_DIV   = 125,
  parameter logic [7:0]  DEV_ID    = 8'h78,
  parameter int          REG_NUM   = 250,
  parameter int          START_DLY = 50_000,
  parameter int          GAP_TICKS = 4
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        power_done,
  output logic [7:0]  cfg_index,
  input  logic [23:0] cfg_data,
  output logic        sio_c,
  output logic        sio_d_out,
  output logic        sio_d_oe,
  input  logic        sio_d_in,
`ifdef SCCB_ACK_CHK_EN
  output logic        cfg_err,
`endif
  output logic        cfg_busy,
  output logic        cfg_done
);

  localparam int DIV_W = (SCL_DIV > 1) ? $clog2(SCL_DIV) : 1;
  localparam int DLY_W = $clog2(START_DLY + 1);

  typedef enum logic [2:0] {
    IDLE, DLY, LOAD, START, BYTE, STOP, GAP, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [7:0]         ph_q, ph_d;
  logic [3:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic [31:0]        sh_q, sh_d;
  logic [7:0]         idx_q, idx_d;
  logic               c_q, c_d;
  logic               d_q, d_d;
  logic               oe_q, oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fin_q, fin_d;
  logic               run, tick, last;
`ifdef SCCB_ACK_CHK_EN
  logic               nack_q, nack_d;
  logic [3:0]         rty_q, rty_d;
  logic               err_q, err_d;
`else
  logic               unused_sio_d_in;
  assign unused_sio_d_in = sio_d_in;
`endif

  assign run  = (state_q == START) || (state_q == BYTE) ||
                (state_q == STOP)  || (state_q == GAP);
  assign tick = run && (div_q == DIV_W'(SCL_DIV - 1));
  assign last = (idx_q == 8'(REG_NUM - 1));

  // Next-state, quarter-tick bus sequencing and table walk.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    dly_d   = dly_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    c_d     = c_q;
    d_d     = d_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fin_d   = fin_q;
`ifdef SCCB_ACK_CHK_EN
    nack_d  = nack_q;
    rty_d   = rty_q;
    err_d   = err_q;
`endif
    if (run && !tick) div_d = div_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (power_done) begin
          state_d = DLY;
          dly_d   = '0;
        end
      end
      DLY: begin
        if (dly_q == DLY_W'(START_DLY - 1)) begin
          state_d = LOAD;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      LOAD: begin
        sh_d    = {DEV_ID, cfg_data};
        state_d = START;
        ph_d    = '0;
        c_d     = 1'b1;
        d_d     = 1'b0;
        oe_d    = 1'b1;
        busy_d  = 1'b1;
`ifdef SCCB_ACK_CHK_EN
        nack_d  = 1'b0;
`endif
      end
      START: begin
        if (tick) begin
          if (ph_q == 8'd0) begin
            ph_d = 8'd1;
            c_d  = 1'b0;
          end else begin
            state_d = BYTE;
            ph_d    = '0;
            bit_d   = '0;
            byte_d  = '0;
            d_d     = sh_q[31];
          end
        end
      end
      BYTE: begin
        if (tick) begin
          unique case (ph_q[1:0])
            2'd0: begin
              c_d  = 1'b1;
              ph_d = 8'd1;
            end
            2'd1: ph_d = 8'd2;
            2'd2: begin
              c_d  = 1'b0;
              ph_d = 8'd3;
`ifdef SCCB_ACK_CHK_EN
              if (bit_q == 4'd8 && sio_d_in) nack_d = 1'b1;
`endif
            end
            2'd3: begin
              ph_d = '0;
              if (bit_q == 4'd8) begin
                oe_d = 1'b1;
                if (byte_q == 2'd3) begin
                  state_d = STOP;
                  d_d     = 1'b0;
                end else begin
                  byte_d = byte_q + 1'b1;
                  bit_d  = '0;
                  d_d    = sh_q[31];
                end
              end else begin
                bit_d = bit_q + 1'b1;
                sh_d  = sh_q << 1;
                if (bit_q == 4'd7) begin
                  d_d  = 1'b1;
                  oe_d = 1'b0;
                end else begin
                  d_d = sh_q[30];
                end
              end
            end
            default: ph_d = '0;
          endcase
        end
      end
      STOP: begin
        if (tick) begin
          if (ph_q == 8'd0) begin
            c_d  = 1'b1;
            ph_d = 8'd1;
          end else if (ph_q == 8'd1) begin
            d_d  = 1'b1;
            ph_d = 8'd2;
          end else begin
            state_d = GAP;
            ph_d    = '0;
            fin_d   = last;
            if (!last) idx_d = idx_q + 1'b1;
`ifdef SCCB_ACK_CHK_EN
            if (nack_q && rty_q != 4'd7) begin
              rty_d = rty_q + 1'b1;
              fin_d = 1'b0;
              idx_d = idx_q;
            end else begin
              rty_d = '0;
              if (nack_q) err_d = 1'b1;
            end
`endif
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (ph_q == 8'(GAP_TICKS - 1)) begin
            ph_d = '0;
            if (fin_q) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered bus outputs.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      dly_q   <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      c_q     <= 1'b1;
      d_q     <= 1'b1;
      oe_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef SCCB_ACK_CHK_EN
      nack_q  <= 1'b0;
      rty_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dly_q   <= dly_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      d_q     <= d_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fin_q   <= fin_d;
`ifdef SCCB_ACK_CHK_EN
      nack_q  <= nack_d;
      rty_q   <= rty_d;
      err_q   <= err_d;
`endif
    end
  end

  assign cfg_index = idx_q;
  assign sio_c     = c_q;
  assign sio_d_out = d_q;
  assign sio_d_oe  = oe_q;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;
`ifdef SCCB_ACK_CHK_EN
  assign cfg_err   = err_q;
`endif

endmodule

// File: tb/tb_ov5640_sccb_cfg.sv
// Bench for ov5640_sccb_cfg: SCCB bus decoder, ROM model, frame scoreboard.
// Honours SCCB_ACK_CHK_EN with a NACKing slave model.
module tb_ov5640_sccb_cfg;

  localparam int         DIV   = 2;
  localparam int         DLY   = 10;
  localparam int         NREG  = 3;
  localparam logic [7:0] DEVID = 8'h78;

  logic        sclk = 1'b0;
  logic        s_rst_n, power_done;
  logic [7:0]  cfg_index;
  logic [23:0] cfg_data;
  logic        sio_c, sio_d_out, sio_d_oe, sio_d_in;
  logic        cfg_busy, cfg_done, nack_now;
  logic [7:0]  idx1;
  logic        c1, d1, oe1, busy1, done1;
`ifdef SCCB_ACK_CHK_EN
  logic        cfg_err, err1;
`endif

  logic [23:0] tbl [NREG];
  int          nack_left [NREG];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  always @(posedge sclk)
    cfg_data <= (cfg_index < NREG) ? tbl[cfg_index[1:0]] : 24'h0;

  assign nack_now = (cfg_index < NREG) ?
                    (nack_left[cfg_index[1:0]] > 0) : 1'b0;
  assign sio_d_in = sio_d_oe ? sio_d_out : nack_now;

  ov5640_sccb_cfg #(
    .SCL_DIV(DIV), .DEV_ID(DEVID), .REG_NUM(NREG),
    .START_DLY(DLY), .GAP_TICKS(4)
  ) u0 (
    .sclk(sclk), .s_rst_n(s_rst_n), .power_done(power_done),
    .cfg_index(cfg_index), .cfg_data(cfg_data),
    .sio_c(sio_c), .sio_d_out(sio_d_out), .sio_d_oe(sio_d_oe),
    .sio_d_in(sio_d_in),
`ifdef SCCB_ACK_CHK_EN
    .cfg_err(cfg_err),
`endif
    .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  ov5640_sccb_cfg #(
    .SCL_DIV(DIV), .DEV_ID(DEVID), .REG_NUM(1),
    .START_DLY(DLY), .GAP_TICKS(4)
  ) u1 (
    .sclk(sclk), .s_rst_n(s_rst_n), .power_done(power_done),
    .cfg_index(idx1), .cfg_data(24'h300882),
    .sio_c(c1), .sio_d_out(d1), .sio_d_oe(oe1),
    .sio_d_in(oe1 ? d1 : 1'b0),
`ifdef SCCB_ACK_CHK_EN
    .cfg_err(err1),
`endif
    .cfg_busy(busy1), .cfg_done(done1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference plan: each entry is sent once, or once per NACK plus the
  // final good attempt, capped at 8 attempts.
  task automatic push_plan(output int n, output bit err);
    n = 0;
    err = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      int a;
      a = (nack_left[i] >= 8) ? 8 : nack_left[i] + 1;
      if (nack_left[i] >= 8) err = 1'b1;
      for (int k = 0; k < a; k++) exp_q.push_back({DEVID, tbl[i]});
      n += a;
    end
  endtask

  logic        pc = 1'b1, pd = 1'b1, inf = 1'b0, rise_ok = 1'b0;
  logic        p1c = 1'b1, p1d = 1'b1;
  logic [31:0] frm;
  int          bitn = 0, last_rise = 0, frames = 0, c_edges = 0;
  int          first_start = -1, starts1 = 0;
  logic        first_busy;

  // Bus monitor: decodes START/bits/STOP and pops the scoreboard.
  always @(negedge sclk) begin
    if (!s_rst_n) begin
      inf = 1'b0; pc = 1'b1; pd = 1'b1; bitn = 0; rise_ok = 1'b0;
      p1c = 1'b1; p1d = 1'b1; starts1 = 0;
    end else begin
      if (c1 && p1c && p1d && !d1) starts1++;
      p1c = c1; p1d = d1;
      if (sio_c != pc) c_edges++;
      if (sio_c && pc && pd && !sio_d_in) begin
        if (inf) chk("start_inside_frame", bitn, 0);
        inf = 1'b1; bitn = 0; frm = '0; rise_ok = 1'b0;
        if (first_start < 0) begin
          first_start = cyc;
          first_busy = cfg_busy;
        end
      end else if (sio_c && pc && !pd && sio_d_in) begin
        if (inf) begin
          chk("frame_bits", bitn, 36);
          if (exp_q.size() == 0) chk("frame_expected", 0, 1);
          else chk("frame_bytes", frm, exp_q.pop_front());
          frames++;
          if (nack_left[cfg_index[1:0]] > 0)
            nack_left[cfg_index[1:0]]--;
        end
        inf = 1'b0;
      end else if (inf && sio_c && !pc) begin
        if (rise_ok) chk("scl_period", cyc - last_rise, 4 * DIV);
        last_rise = cyc; rise_ok = 1'b1;
        if (bitn < 36) begin
          if (bitn % 9 == 8) chk("ack_oe", sio_d_oe, 0);
          else begin
            chk("data_oe", sio_d_oe, 1);
            frm = {frm[30:0], sio_d_in};
          end
          bitn++;
        end
      end else if (inf && !sio_c && pc && rise_ok) begin
        chk("scl_high", cyc - last_rise, 2 * DIV);
      end
      pc = sio_c; pd = sio_d_in;
    end
  end

  task automatic wait_done(input string nm);
    int i;
    i = 0;
    while (!cfg_done && i < 8000) begin
      @(posedge sclk);
      i++;
    end
    @(negedge sclk);
    chk(nm, cfg_done, 1);
  endtask

  task automatic do_reset();
    @(posedge sclk);
    #1 s_rst_n = 1'b0;
    power_done = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge sclk);
    #1 s_rst_n = 1'b1;
  endtask

  initial begin
    int n, i, snap;
    bit err;
    s_rst_n = 1'b0;
    power_done = 1'b0;
    tbl[0] = 24'h310311; tbl[1] = 24'h300882; tbl[2] = 24'h3017FF;
    for (int k = 0; k < NREG; k++) nack_left[k] = 0;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    chk("rst_cfg_index", cfg_index, 0);
    chk("rst_sio_c", sio_c, 1);
    chk("rst_sio_d_out", sio_d_out, 1);
    chk("rst_sio_d_oe", sio_d_oe, 1);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_cfg_done", cfg_done, 0);
`ifdef SCCB_ACK_CHK_EN
    chk("rst_cfg_err", cfg_err, 0);
`endif
    #1 s_rst_n = 1'b1;

    while (cyc < 100) @(posedge sclk);
    #1;
    frames = 0;
    push_plan(n, err);
    snap = cyc;
    power_done = 1'b1;
    i = 0;
    while (first_start < 0 && i < 300) begin
      @(posedge sclk);
      i++;
    end
    chk("first_start_seen", first_start >= 0, 1);
    chk("start_latency", (first_start - snap >= DLY + 1) &&
                         (first_start - snap <= DLY + 3), 1);
    chk("busy_at_start", first_busy, 1);
    wait_done("done_run_a");
    chk("busy_after_done", cfg_busy, 0);
    chk("frames_run_a", frames, n);
    chk("queue_empty_a", exp_q.size(), 0);
    chk("final_index", cfg_index, NREG - 1);
    chk("one_entry_done", done1, 1);
    chk("one_entry_starts", starts1, 1);
    chk("one_entry_index", idx1, 0);
    snap = c_edges;
    repeat (100) @(posedge sclk);
    chk("no_scl_after_done", c_edges - snap, 0);

    do_reset();
    for (int k = 0; k < NREG; k++) tbl[k] = 24'($urandom);
    frames = 0;
    push_plan(n, err);
    power_done = 1'b1;
    i = 0;
    while (!(inf && cfg_index == 1 && bitn >= 18 && bitn < 27) &&
           i < 3000) begin
      @(posedge sclk);
      i++;
    end
    chk("reached_entry1_byte2", inf && cfg_index == 1, 1);
    #1 s_rst_n = 1'b0;
    power_done = 1'b0;
    exp_q.delete();
    @(negedge sclk);
    chk("mid_rst_sio_c", sio_c, 1);
    chk("mid_rst_sio_d_out", sio_d_out, 1);
    chk("mid_rst_index", cfg_index, 0);
    chk("mid_rst_done", cfg_done, 0);
    repeat (2) @(posedge sclk);
    #1 s_rst_n = 1'b1;
    for (int k = 0; k < NREG; k++) tbl[k] = 24'($urandom);
    frames = 0;
    push_plan(n, err);
    repeat (5) @(posedge sclk);
    #1 power_done = 1'b1;
    i = 0;
    while (frames == 0 && i < 3000) begin
      @(posedge sclk);
      i++;
    end
    power_done = 1'b0;
    wait_done("done_run_b");
    chk("frames_run_b", frames, n);
    chk("queue_empty_b", exp_q.size(), 0);

`ifdef SCCB_ACK_CHK_EN
    do_reset();
    nack_left[1] = 2;
    frames = 0;
    push_plan(n, err);
    power_done = 1'b1;
    wait_done("done_retry");
    chk("frames_retry", frames, n);
    chk("err_retry", cfg_err, err);
    do_reset();
    nack_left[1] = 100;
    frames = 0;
    push_plan(n, err);
    power_done = 1'b1;
    wait_done("done_skip");
    chk("frames_skip", frames, n);
    chk("queue_empty_skip", exp_q.size(), 0);
    chk("err_skip", cfg_err, err);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
